// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared word size, PC step, FSM state encoding and redirect source codes.
package fetch_sequencer_pkg;
   localparam int WORD = 32;
   localparam int PC_INCREMENT = 4;
   typedef enum logic [1:0] {FS_BOOT, FS_REQ, FS_WAIT, FS_HOLD} fetchState_t;
   localparam logic [1:0] REDIR_NONE = 2'd0;
   localparam logic [1:0] REDIR_JMP  = 2'd1;
   localparam logic [1:0] REDIR_BR   = 2'd2;
   localparam logic [1:0] REDIR_EXCP = 2'd3;
endpackage

// File: rtl/fetch_sequencer_redirect_prio_mux.sv
// fetch_sequencer_redirect_prio_mux: picks one redirect per cycle, exception > branch > jump.
module fetch_sequencer_redirect_prio_mux
   import fetch_sequencer_pkg::*;
#(
   parameter int XLEN = WORD
) (
   input  logic            excpValid,
   input  logic [XLEN-1:0] excpAddr,
   input  logic            brValid,
   input  logic [XLEN-1:0] brAddr,
   input  logic            jmpValid,
   input  logic [XLEN-1:0] jmpAddr,
   output logic            valid,
   output logic [XLEN-1:0] target,
   output logic [1:0]      src
);
   always_comb begin
      valid  = excpValid | brValid | jmpValid;
      target = excpValid ? excpAddr : brValid ? brAddr : jmpAddr;
      src    = excpValid ? REDIR_EXCP : brValid ? REDIR_BR : jmpValid ? REDIR_JMP : REDIR_NONE;
   end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: next-PC select, req/gnt/rvalid fetch port and decode hand-off.
// FETCH_MISALIGN_CHK_EN adds misalign_o and parks fetch in BOOT on a misaligned redirect target.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int              XLEN     = WORD,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              PC_INC   = PC_INCREMENT
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            excp_valid_i,
   input  logic [XLEN-1:0] excp_addr_i,
   input  logic            br_valid_i,
   input  logic [XLEN-1:0] br_addr_i,
   input  logic            jmp_valid_i,
   input  logic [XLEN-1:0] jmp_addr_i,
   input  logic            stall_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic            inst_valid_o,
   output logic [XLEN-1:0] inst_o,
   output logic [XLEN-1:0] inst_pc_o,
`ifdef FETCH_MISALIGN_CHK_EN
   output logic            misalign_o,
`endif
   output logic [1:0]      redir_src_o
);
   fetchState_t     stateQ, stateD;
   logic [XLEN-1:0] pcQ, pcD, inflightPcQ, inflightPcD, instQ, instD, instPcQ, instPcD;
   logic [XLEN-1:0] redirTarget;
   logic [1:0]      srcQ, srcD, redirSrc;
   logic            killQ, killD, parkQ, parkD, redirValid, misAl, pendNext;

   fetch_sequencer_redirect_prio_mux #(.XLEN(XLEN)) prioMux (
      .excpValid(excp_valid_i),
      .excpAddr (excp_addr_i),
      .brValid  (br_valid_i),
      .brAddr   (br_addr_i),
      .jmpValid (jmp_valid_i),
      .jmpAddr  (jmp_addr_i),
      .valid    (redirValid),
      .target   (redirTarget),
      .src      (redirSrc)
   );

`ifdef FETCH_MISALIGN_CHK_EN
   assign misAl = |redirTarget[1:0];
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) misalign_o <= 1'b0;
      else misalign_o <= redirValid & misAl;
`else
   assign misAl = 1'b0;
`endif

   assign imem_req_o   = stateQ == FS_REQ;
   assign imem_addr_o  = pcQ;
   assign inst_valid_o = stateQ == FS_HOLD;
   assign inst_o       = instQ;
   assign inst_pc_o    = instPcQ;
   assign redir_src_o  = srcQ;

   always_comb begin
      stateD      = stateQ;
      pcD         = pcQ;
      inflightPcD = inflightPcQ;
      instD       = instQ;
      instPcD     = instPcQ;
      srcD        = srcQ;
      killD       = killQ;
      parkD       = parkQ;
      // a memory response will still be owed after this cycle
      pendNext    = (stateQ == FS_REQ && imem_gnt_i) || ((stateQ == FS_WAIT || killQ) && !imem_rvalid_i);
      case (stateQ)
         FS_BOOT: begin
            killD  = killQ & ~imem_rvalid_i;
            stateD = parkQ ? FS_BOOT : FS_REQ;
         end
         FS_REQ: if (imem_gnt_i) begin
            stateD      = FS_WAIT;
            inflightPcD = pcQ;
            pcD         = pcQ + XLEN'(PC_INC);
         end
         FS_WAIT: if (imem_rvalid_i) begin
            stateD  = killQ ? FS_REQ : FS_HOLD;
            killD   = 1'b0;
            instD   = killQ ? instQ : imem_rdata_i;
            instPcD = killQ ? instPcQ : inflightPcQ;
         end
         default: stateD = stall_i ? FS_HOLD : FS_REQ;
      endcase
      // redirect overrides the sequential path; anything still owed becomes wrong-path
      if (redirValid) begin
         srcD    = redirSrc;
         killD   = pendNext;
         instD   = instQ;
         instPcD = instPcQ;
         pcD     = misAl ? pcD : redirTarget;
         parkD   = misAl;
         stateD  = misAl ? FS_BOOT : pendNext ? FS_WAIT : FS_REQ;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stateQ      <= FS_BOOT;
         pcQ         <= RESET_PC;
         inflightPcQ <= '0;
         instQ       <= '0;
         instPcQ     <= '0;
         srcQ        <= REDIR_NONE;
         killQ       <= 1'b0;
         parkQ       <= 1'b0;
      end else begin
         stateQ      <= stateD;
         pcQ         <= pcD;
         inflightPcQ <= inflightPcD;
         instQ       <= instD;
         instPcQ     <= instPcD;
         srcQ        <= srcD;
         killQ       <= killD;
         parkQ       <= parkD;
      end
   end
endmodule
